nco_dds: RTL and testbench
==========================

// Module: nco_dds
// PURPOSE
//   Numerically controlled oscillator producing quadrature sine/cosine samples for the modulator datapath.
//   A 25-bit phase accumulator advances by phi_inc_i + freq_mod_i on each enabled clock.
//   A pipelined CORDIC (rotation mode) converts the accumulated phase to 15-bit signed sin/cos.
//   Serves as the carrier/frequency-modulated (MSK/FSK) source ahead of the DAC interface.
// PARAMETERS
//   PHASE_W   25   accumulator and increment width (phase wraps mod 2^PHASE_W)
//   OUT_W     15   sin/cos output width, two's complement
//   CORDIC_N  16   CORDIC micro-rotation stages; phase into CORDIC = acc[PHASE_W-1 -: CORDIC_N]
//   LATENCY   CORDIC_N+3   enabled clocks from accumulator update to output register (derived, localparam)
// PORTS
//   clk         in   1        clock; all logic on rising edge
//   reset_n     in   1        reset; synchronous, active-low
//   clken       in   1        clock enable; 0 freezes every register, including out_valid
//   phi_inc_i   in   25       unsigned base phase increment per sample
//   freq_mod_i  in   25       unsigned modulation increment, added to phi_inc_i (mod 2^25)
//   fsin_o      out  15       signed sine sample
//   fcos_o      out  15       signed cosine sample
//   out_valid   out  1        high once pipeline filled since last reset
// BEHAVIOUR
// - Reset (reset_n=0 at posedge, clken ignored): acc=0, all pipeline regs=0, fsin_o=0, fcos_o=0, out_valid=0.
// - Enabled edge (reset_n=1, clken=1): acc <= acc + phi_inc_i + freq_mod_i (25-bit wrap, carries discarded).
// - Inputs sampled only on enabled edges; a changed increment affects the next accumulator step, no glitch.
// - Phase pipeline: stage 1 registers acc; stage 2 maps quadrant (top 2 phase bits) onto +/-90 deg;
//   stages 3..CORDIC_N+2 perform CORDIC iterations with an arctan ROM of CORDIC_N constants;
//   final stage applies quadrant sign/swap and registers fsin_o/fcos_o.
// - Sample k output (k=0 first valid) = amplitude * sin/cos(2*pi * phase_k / 2^25), phase_0 = 0.
// - Amplitude: peak 16383 (2^14-1); CORDIC gain pre-compensated in initial x; results saturated to
//   [-16383,+16383] (value -16384 never emitted). Error <= 2 LSB versus ideal rounded value.
// - out_valid: internal fill counter counts enabled edges after reset release;
//   out_valid rises on the LATENCY-th enabled edge, then stays 1 until reset.
// - clken=0: state, outputs and out_valid hold; pipeline resumes without loss or duplication.
// - Reset mid-operation: immediate clear as above; full refill (out_valid low LATENCY enabled edges).
// - Phase wrap from 0x1FFFFFF to 0x0000000 produces a continuous waveform, no discontinuity.
// - Sum phi_inc_i+freq_mod_i >= 2^24 aliases (above Nyquist); no detection, wraps arithmetically.
// CONFIGURATION
//   PHASE_DITHER_EN  defined: 9-bit maximal-length LFSR (seed 9'h1FF on reset, steps on enabled edges)
//                    is added to acc bits below the CORDIC phase slice before truncation, reducing
//                    phase-truncation spurs; adds no latency.
//                    undefined: plain truncation, fully deterministic outputs (default for regression).
// TESTING (PHASE_DITHER_EN undefined)
// - Quarter-rate: phi_inc_i=25'h0600000, freq_mod_i=25'h0200000, reset 7 cycles then release ->
//   after LATENCY enabled edges out_valid=1; sin: 0,16383,0,-16383,... cos: 16383,0,-16383,0,... (+/-2 LSB).
// - Reset values: hold reset_n=0 with nonzero inputs -> fsin_o=0, fcos_o=0, out_valid=0 every cycle.
// - clken gating: drop clken for 5 cycles mid-stream -> outputs/out_valid frozen; sequence resumes
//   with next expected sample, none skipped or repeated.
// - Wrap/freq step: phi_inc_i=25'h1000000 (half rate) -> sin 0,0,...; cos alternates 16383,-16383;
//   then switch freq_mod_i to 25'h0080000 -> phase step becomes 0x1080000, continuous phase.
// - Reset mid-run: assert reset_n=0 one cycle during output -> out_valid=0 next edge, refill, restart at phase 0.
// - Slow sweep: phi_inc_i=25'h0000800 -> 16384 samples/period; peak |sin|,|cos| = 16383, never -16384.

Source files
------------

// File: rtl/nco_dds.sv
// nco_dds: 25-bit phase accumulator feeding a CORDIC_N-stage rotation CORDIC; LATENCY = CORDIC_N+3 enabled clocks,
// no backpressure (clken=0 stalls every register). Define PHASE_DITHER_EN to add 9-bit LFSR dither below the phase slice.
module nco_dds #(
  parameter int PHASE_W  = 25,
  parameter int OUT_W    = 15,
  parameter int CORDIC_N = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic [PHASE_W-1:0]      phi_inc_i,
  input  logic [PHASE_W-1:0]      freq_mod_i,
  output logic signed [OUT_W-1:0] fsin_o,
  output logic signed [OUT_W-1:0] fcos_o,
  output logic                    out_valid
);

  localparam int LATENCY = CORDIC_N + 3;
  localparam int CNT_W   = $clog2(LATENCY);
  localparam int GRD     = 6;
  localparam int XW      = OUT_W + GRD + 2;
  localparam int ZW      = 26;
  localparam int ZF      = 24 - CORDIC_N;
  localparam int RES_W   = CORDIC_N - 2;
  localparam int ZPAD    = ZW - RES_W - ZF;
  // Start vector (2^14-1)*2^GRD divided by the 16-stage CORDIC gain 1.6467602578.
  localparam logic signed [XW-1:0]    X_INIT = XW'(636712);
  localparam logic signed [XW-1:0]    AMP    = XW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [OUT_W-1:0] AMP_O  = OUT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [XW-1:0]    HALF   = XW'(1 << (GRD - 1));

  // atan(2^-i) in units of 2^-24 of a full turn.
  function automatic logic signed [ZW-1:0] atan_rom(input int idx);
    case (idx)
      0:       atan_rom = ZW'(2097152);
      1:       atan_rom = ZW'(1238021);
      2:       atan_rom = ZW'(654136);
      3:       atan_rom = ZW'(332050);
      4:       atan_rom = ZW'(166669);
      5:       atan_rom = ZW'(83416);
      6:       atan_rom = ZW'(41718);
      7:       atan_rom = ZW'(20860);
      8:       atan_rom = ZW'(10430);
      9:       atan_rom = ZW'(5215);
      10:      atan_rom = ZW'(2608);
      11:      atan_rom = ZW'(1304);
      12:      atan_rom = ZW'(652);
      13:      atan_rom = ZW'(326);
      14:      atan_rom = ZW'(163);
      15:      atan_rom = ZW'(81);
      default: atan_rom = '0;
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [XW-1:0] v);
    if (v > AMP)       sat = AMP_O;
    else if (v < -AMP) sat = -AMP_O;
    else               sat = v[OUT_W-1:0];
  endfunction

  logic [PHASE_W-1:0]      acc;
  logic [CORDIC_N-1:0]     phase_slice;
  logic [CORDIC_N-1:0]     ph1;
  logic signed [XW-1:0]    x_init_q, y_init_q;
  logic signed [ZW-1:0]    z_init_q;
  logic [1:0]              q_init_q;
  logic [CNT_W-1:0]        fill_cnt;

  logic signed [XW-1:0]    xs [0:CORDIC_N];
  logic signed [XW-1:0]    ys [0:CORDIC_N];
  logic signed [ZW-1:0]    zs [0:CORDIC_N-1];
  logic [1:0]              qs [0:CORDIC_N];

`ifdef PHASE_DITHER_EN
  logic [8:0]         lfsr;
  logic [PHASE_W-1:0] acc_dith;

  always_ff @(posedge clk) begin
    if (!reset_n)   lfsr <= 9'h1FF;
    else if (clken) lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
  end

  assign acc_dith    = acc + PHASE_W'(lfsr);
  assign phase_slice = acc_dith[PHASE_W-1 -: CORDIC_N];
`else
  assign phase_slice = acc[PHASE_W-1 -: CORDIC_N];
`endif

  // Stage 1 captures the phase; stage 2 splits it into quadrant and a 0..90 deg residual.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc       <= '0;
      ph1       <= '0;
      x_init_q  <= '0;
      y_init_q  <= '0;
      z_init_q  <= '0;
      q_init_q  <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (clken) begin
      acc      <= acc + phi_inc_i + freq_mod_i;
      ph1      <= phase_slice;
      q_init_q <= ph1[CORDIC_N-1 -: 2];
      x_init_q <= X_INIT;
      y_init_q <= '0;
      z_init_q <= {{ZPAD{1'b0}}, ph1[RES_W-1:0], {ZF{1'b0}}};
      if (!out_valid) begin
        if (fill_cnt == CNT_W'(LATENCY - 1)) out_valid <= 1'b1;
        else                                 fill_cnt  <= fill_cnt + 1'b1;
      end
    end
  end

  assign xs[0] = x_init_q;
  assign ys[0] = y_init_q;
  assign zs[0] = z_init_q;
  assign qs[0] = q_init_q;

  for (genvar g = 0; g < CORDIC_N; g++) begin : g_rot
    logic signed [XW-1:0] x_q, y_q;
    logic [1:0]           q_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        x_q <= '0;
        y_q <= '0;
        q_q <= '0;
      end else if (clken) begin
        q_q <= qs[g];
        if (zs[g][ZW-1]) begin
          x_q <= xs[g] + (ys[g] >>> g);
          y_q <= ys[g] - (xs[g] >>> g);
        end else begin
          x_q <= xs[g] - (ys[g] >>> g);
          y_q <= ys[g] + (xs[g] >>> g);
        end
      end
    end

    assign xs[g+1] = x_q;
    assign ys[g+1] = y_q;
    assign qs[g+1] = q_q;

    // The residual angle is not needed after the last rotation.
    if (g < CORDIC_N - 1) begin : g_z
      localparam logic signed [ZW-1:0] ATAN = atan_rom(g);
      logic signed [ZW-1:0] z_q;

      always_ff @(posedge clk) begin
        if (!reset_n)   z_q <= '0;
        else if (clken) z_q <= zs[g][ZW-1] ? zs[g] + ATAN : zs[g] - ATAN;
      end

      assign zs[g+1] = z_q;
    end
  end

  logic signed [XW-1:0]    x_rnd, y_rnd;
  logic signed [OUT_W-1:0] x_sat, y_sat, sin_nxt, cos_nxt;

  // Round and clamp before the quadrant swap so negation can never overflow.
  always_comb begin
    x_rnd   = (xs[CORDIC_N] + HALF) >>> GRD;
    y_rnd   = (ys[CORDIC_N] + HALF) >>> GRD;
    x_sat   = sat(x_rnd);
    y_sat   = sat(y_rnd);
    sin_nxt = y_sat;
    cos_nxt = x_sat;
    case (qs[CORDIC_N])
      2'd0: begin sin_nxt =  y_sat; cos_nxt =  x_sat; end
      2'd1: begin sin_nxt =  x_sat; cos_nxt = -y_sat; end
      2'd2: begin sin_nxt = -y_sat; cos_nxt = -x_sat; end
      default: begin sin_nxt = -x_sat; cos_nxt =  y_sat; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsin_o <= '0;
      fcos_o <= '0;
    end else if (clken) begin
      fsin_o <= sin_nxt;
      fcos_o <= cos_nxt;
    end
  end

endmodule

// File: tb/tb_nco_dds.sv
// Directed bench for nco_dds: reset, quarter/half rate, clken stall, frequency step, mid-run reset, slow sweep.
module tb_nco_dds;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clken;
  logic [24:0]        phi_inc_i;
  logic [24:0]        freq_mod_i;
  logic signed [14:0] fsin_o;
  logic signed [14:0] fcos_o;
  logic               out_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int sin_tab [4] = '{0, 16383, 0, -16383};
  int cos_tab [4] = '{16383, 0, -16383, 0};
  int kq;

  // Reference phase history: acc captured on each enabled edge, output 18 edges later.
  logic [24:0] acc_m;
  logic [24:0] cap_q [$];

  nco_dds dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clken      (clken),
    .phi_inc_i  (phi_inc_i),
    .freq_mod_i (freq_mod_i),
    .fsin_o     (fsin_o),
    .fcos_o     (fcos_o),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) begin
      acc_m = '0;
      cap_q.delete();
    end else if (clken) begin
      cap_q.push_back(acc_m);
      if (cap_q.size() > 19) void'(cap_q.pop_front());
      acc_m = acc_m + phi_inc_i + freq_mod_i;
    end
  end

  function automatic int ideal(input bit want_sin, input logic [24:0] ph);
    real a, r;
    a = 2.0 * 3.141592653589793 * real'(ph) / 33554432.0;
    r = 16383.0 * (want_sin ? $sin(a) : $cos(a));
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int s, c;
    reset_n    = 1'b0;
    phi_inc_i  = 25'h0ABCDEF;
    freq_mod_i = 25'h0012345;
    for (int i = 0; i < 4; i++) begin
      clken = (i == 2) ? 1'b0 : 1'b1;
      tick();
      s = fsin_o;
      c = fcos_o;
      total_cnt++;
      if (s !== 0) $display("FAIL reset_sin cyc%0d: got %0d want 0", i, s); else pass_cnt++;
      total_cnt++;
      if (c !== 0) $display("FAIL reset_cos cyc%0d: got %0d want 0", i, c); else pass_cnt++;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid cyc%0d: got %b want 0", i, out_valid); else pass_cnt++;
    end
  endtask

  task automatic test_quarter_rate();
    int s, c;
    clken      = 1'b1;
    phi_inc_i  = 25'h0600000;
    freq_mod_i = 25'h0200000;
    reset_n    = 1'b0;
    repeat (7) tick();
    reset_n = 1'b1;
    repeat (18) tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL quarter_fill_low: got %b want 0", out_valid); else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL quarter_valid_rise: got %b want 1", out_valid); else pass_cnt++;
    for (kq = 0; kq < 8; kq++) begin
      if (kq > 0) tick();
      s = fsin_o;
      c = fcos_o;
      total_cnt++;
      if (iabs(s - sin_tab[kq % 4]) > 2 || iabs(c - cos_tab[kq % 4]) > 2)
        $display("FAIL quarter_k%0d: got sin=%0d cos=%0d want %0d/%0d", kq, s, c, sin_tab[kq % 4], cos_tab[kq % 4]);
      else pass_cnt++;
    end
    kq = 7;
  endtask

  task automatic test_clken_gating();
    logic signed [14:0] hs, hc;
    int s, c;
    hs    = fsin_o;
    hc    = fcos_o;
    clken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({fsin_o, fcos_o, out_valid} !== {hs, hc, 1'b1})
        $display("FAIL clken_hold cyc%0d: got %0d/%0d/%b want %0d/%0d/1", i, fsin_o, fcos_o, out_valid, hs, hc);
      else pass_cnt++;
    end
    clken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      kq++;
      s = fsin_o;
      c = fcos_o;
      total_cnt++;
      if (iabs(s - sin_tab[kq % 4]) > 2 || iabs(c - cos_tab[kq % 4]) > 2)
        $display("FAIL clken_resume_k%0d: got sin=%0d cos=%0d want %0d/%0d", kq, s, c, sin_tab[kq % 4], cos_tab[kq % 4]);
      else pass_cnt++;
    end
  endtask

  task automatic test_half_rate_step();
    int s, c, es, ec;
    phi_inc_i  = 25'h1000000;
    freq_mod_i = 25'h0000000;
    reset_n    = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (19) tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      s  = fsin_o;
      c  = fcos_o;
      ec = (k % 2 == 0) ? 16383 : -16383;
      total_cnt++;
      if (iabs(s) > 2 || iabs(c - ec) > 2)
        $display("FAIL half_rate_k%0d: got sin=%0d cos=%0d want 0/%0d", k, s, c, ec);
      else pass_cnt++;
    end
    freq_mod_i = 25'h0080000;
    for (int k = 0; k < 26; k++) begin
      tick();
      s  = fsin_o;
      c  = fcos_o;
      es = ideal(1'b1, cap_q[0]);
      ec = ideal(1'b0, cap_q[0]);
      total_cnt++;
      if (iabs(s - es) > 2 || iabs(c - ec) > 2)
        $display("FAIL freq_step_s%0d: got sin=%0d cos=%0d want %0d/%0d", k, s, c, es, ec);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int s, c, es, ec;
    reset_n = 1'b0;
    tick();
    total_cnt++;
    if ({out_valid, fsin_o, fcos_o} !== 31'd0)
      $display("FAIL midreset_clear: got valid=%b sin=%0d cos=%0d want 0/0/0", out_valid, fsin_o, fcos_o);
    else pass_cnt++;
    reset_n = 1'b1;
    repeat (18) tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL midreset_fill_low: got %b want 0", out_valid); else pass_cnt++;
    tick();
    s = fsin_o;
    c = fcos_o;
    total_cnt++;
    if (out_valid !== 1'b1 || iabs(s) > 2 || iabs(c - 16383) > 2)
      $display("FAIL midreset_restart: got valid=%b sin=%0d cos=%0d want 1/0/16383", out_valid, s, c);
    else pass_cnt++;
    tick();
    s  = fsin_o;
    c  = fcos_o;
    es = ideal(1'b1, 25'h1080000);
    ec = ideal(1'b0, 25'h1080000);
    total_cnt++;
    if (iabs(s - es) > 2 || iabs(c - ec) > 2)
      $display("FAIL midreset_sample1: got sin=%0d cos=%0d want %0d/%0d", s, c, es, ec);
    else pass_cnt++;
  endtask

  task automatic test_slow_sweep();
    int s, c, err, max_err, smax, smin, cmax, cmin;
    max_err = 0; smax = -99999; smin = 99999; cmax = -99999; cmin = 99999;
    phi_inc_i  = 25'h0000800;
    freq_mod_i = 25'h0000000;
    reset_n    = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (18) tick();
    for (int k = 0; k < 16384 + 4; k++) begin
      tick();
      s   = fsin_o;
      c   = fcos_o;
      err = iabs(s - ideal(1'b1, cap_q[0]));
      if (err > max_err) max_err = err;
      err = iabs(c - ideal(1'b0, cap_q[0]));
      if (err > max_err) max_err = err;
      if (s > smax) smax = s;
      if (s < smin) smin = s;
      if (c > cmax) cmax = c;
      if (c < cmin) cmin = c;
    end
    total_cnt++;
    if (max_err > 2) $display("FAIL sweep_max_err: got %0d want <= 2", max_err); else pass_cnt++;
    total_cnt++;
    if (smax !== 16383 || smin !== -16383) $display("FAIL sweep_sin_peak: got %0d/%0d want 16383/-16383", smax, smin);
    else pass_cnt++;
    total_cnt++;
    if (cmax !== 16383 || cmin !== -16383) $display("FAIL sweep_cos_peak: got %0d/%0d want 16383/-16383", cmax, cmin);
    else pass_cnt++;
  endtask

  initial begin
    reset_n    = 1'b0;
    clken      = 1'b1;
    phi_inc_i  = '0;
    freq_mod_i = '0;
    test_reset();
    test_quarter_rate();
    test_clken_gating();
    test_half_rate_step();
    test_reset_mid();
    test_slow_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
